// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Function : Valid/ready ALU with registered result and carry/zero/overflow
//             flags. Define ALU_PIPE_MUL_EN for the iterative shift-add
//             multiply on ctrl 011; otherwise 011 passes data1 through.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             oCarry,
    output logic             oZero,
    output logic             oOverflow
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HOLD = 2'd2;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [2:0] c_OP_MUL = 3'b011;
`endif

    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_XOR = 3'b111;
    localparam logic [2:0] c_OP_SLL = 3'b100;
    localparam logic [2:0] c_OP_SRL = 3'b101;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_sum  = {1'b0, data1} + {1'b0, data2};
    assign w_diff = {1'b0, data1} - {1'b0, data2};

    always_comb begin
        w_res   = data1;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (ctrl)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != data1[WIDTH-1]);
            end
            c_OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != data1[WIDTH-1]);
            end
            c_OP_AND: w_res = data1 & data2;
            c_OP_OR:  w_res = data1 | data2;
            c_OP_XOR: w_res = data1 ^ data2;
            c_OP_SLL: w_res = data1 << data2[SHW-1:0];
            c_OP_SRL: w_res = data1 >> data2[SHW-1:0];
            default:  w_res = data1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int               c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_start;

    assign in_ready    = (r_state == c_IDLE) || ((r_state == c_HOLD) && out_ready);
    assign w_mul_start = w_accept && (ctrl == c_OP_MUL);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});

    // One partial product per BUSY cycle; multiplicand shifts left, multiplier right
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, data1};
            r_mplier <= data2;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == c_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign in_ready = (r_state == c_IDLE) || out_ready;
`endif

    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == c_HOLD);
    assign out       = r_out;
    assign oCarry    = r_carry;
    assign oZero     = r_zero;
    assign oOverflow = r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_HOLD: begin
`ifdef ALU_PIPE_MUL_EN
                    if (w_mul_start) begin
                        r_state <= c_BUSY;
                    end else
`endif
                    if (w_accept) begin
                        r_state <= c_HOLD;
                        r_out   <= w_res;
                        r_carry <= w_carry;
                        r_zero  <= (w_res == '0);
                        r_ovf   <= w_ovf;
                    end else if ((r_state == c_HOLD) && out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                c_BUSY: begin
                    // Final partial product lands on the edge the count reaches WIDTH
                    if (r_cnt == c_LAST) begin
                        r_state <= c_HOLD;
                        r_out   <= w_acc_next[WIDTH-1:0];
                        r_carry <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
                        r_zero  <= (w_acc_next[WIDTH-1:0] == '0);
                        r_ovf   <= 1'b0;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// Directed self-checking bench for alu_pipe (WIDTH=32); multiply steps are
// included when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ctrl = 3'b000;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        oCarry;
    logic        oZero;
    logic        oOverflow;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .oCarry    (oCarry),
        .oZero     (oZero),
        .oOverflow (oOverflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] o,
                           input logic c, input logic z, input logic v);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_out"},   64'(out),       64'(o));
        chk({tag, "_carry"}, 64'(oCarry),    64'(c));
        chk({tag, "_zero"},  64'(oZero),     64'(z));
        chk({tag, "_ovf"},   64'(oOverflow), 64'(v));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        ctrl     = c;
        data1    = a;
        data2    = b;
    endtask

    initial begin
        // asynchronous reset takes effect without a clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out",   64'(out),       64'd0);
        chk("rst_carry", 64'(oCarry),    64'd0);
        chk("rst_zero",  64'(oZero),     64'd0);
        chk("rst_ovf",   64'(oOverflow), 64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick;
        chk("rel_ready", 64'(in_ready),  64'd1);
        chk("rel_valid", 64'(out_valid), 64'd0);

        // back-to-back single-cycle ops, one result per edge
        out_ready = 1'b1;
        drive(3'b010, 32'hFFFF_FFFF, 32'h0000_0001); tick; chk_res("add_wrap",  32'h0000_0000, 1, 1, 0);
        drive(3'b110, 32'h0000_0005, 32'h0000_0007); tick; chk_res("sub_borrow", 32'hFFFF_FFFE, 1, 0, 0);
        drive(3'b010, 32'h7FFF_FFFF, 32'h0000_0001); tick; chk_res("add_ovf",   32'h8000_0000, 0, 0, 1);
        drive(3'b110, 32'h8000_0000, 32'h0000_0001); tick; chk_res("sub_ovf",   32'h7FFF_FFFF, 0, 0, 1);
        drive(3'b110, 32'h0000_0007, 32'h0000_0005); tick; chk_res("sub_plain", 32'h0000_0002, 0, 0, 0);
        drive(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF); tick; chk_res("and",       32'h00F0_1234, 0, 0, 0);
        drive(3'b000, 32'hFFFF_0000, 32'h0000_FFFF); tick; chk_res("and_zero",  32'h0000_0000, 0, 1, 0);
        drive(3'b001, 32'h0000_00F0, 32'h0F00_0000); tick; chk_res("or",        32'h0F00_00F0, 0, 0, 0);
        drive(3'b100, 32'h0000_0001, 32'h0000_0024); tick; chk_res("sll",       32'h0000_0010, 0, 0, 0);
        drive(3'b101, 32'h8000_0000, 32'h0000_001F); tick; chk_res("srl31",     32'h0000_0001, 0, 0, 0);
        drive(3'b101, 32'h8000_0000, 32'h0000_0020); tick; chk_res("srl_amt0",  32'h8000_0000, 0, 0, 0);
`ifndef ALU_PIPE_MUL_EN
        drive(3'b011, 32'hDEAD_BEEF, 32'h1234_5678); tick; chk_res("op011_pass", 32'hDEAD_BEEF, 0, 0, 0);
`endif
        in_valid = 1'b0;
        tick;
        chk("drain_valid", 64'(out_valid), 64'd0);

        // backpressure: result and flags frozen, new op not taken
        out_ready = 1'b0;
        drive(3'b111, 32'hFF00_FF00, 32'h0F0F_0F0F); tick; chk_res("xor", 32'hF00F_F00F, 0, 0, 0);
        drive(3'b010, 32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk_res("xor_hold", 32'hF00F_F00F, 0, 0, 0);
        end
        out_ready = 1'b1;
        tick;
        chk_res("after_hold", 32'h0000_0003, 0, 0, 0);
        in_valid = 1'b0;
        tick;
        chk("after_hold_idle", 64'(out_valid), 64'd0);

`ifdef ALU_PIPE_MUL_EN
        drive(3'b011, 32'h0000_0007, 32'h0000_0006); tick; in_valid = 1'b0;
        chk("busy_valid", 64'(out_valid), 64'd0);
        chk("busy_ready", 64'(in_ready),  64'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin tick; n++; end
        chk("mul_lat", 64'(n), 64'd32);
        chk_res("mul_7x6", 32'h0000_002A, 0, 0, 0);
        tick;
        drive(3'b011, 32'h0001_0000, 32'h0001_0000); tick; in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin tick; n++; end
        chk("mul_big_lat", 64'(n), 64'd32);
        chk_res("mul_big", 32'h0000_0000, 1, 1, 0);
        tick;

        // reset at cycle 10 of a multiply
        drive(3'b011, 32'h0000_0003, 32'h0000_0005); tick; in_valid = 1'b0;
        repeat (9) tick;
`else
        out_ready = 1'b0;
        drive(3'b111, 32'h0000_0001, 32'h0000_0003); tick; in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
`endif
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out",   64'(out),       64'd0);
        chk("mid_rst_carry", 64'(oCarry),    64'd0);
        chk("mid_rst_zero",  64'(oZero),     64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        tick;
        chk("rel2_ready", 64'(in_ready), 64'd1);
        n = 0;
        repeat (40) begin
            tick;
            if (out_valid === 1'b1) n++;
        end
        chk("no_stale_result", 64'(n), 64'd0);
        chk("rel2_out", 64'(out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning the shift-amount width taken from data2[SHW-1:0].
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation presented.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operation this cycle.
REQ-007 SHALL have port ctrl, input, 3, operation select.
REQ-008 SHALL have ports data1 and data2, input, WIDTH each, operands.
REQ-009 SHALL have port out_valid, output, 1, result registered and held.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port out, output, WIDTH, registered result.
REQ-012 SHALL have ports oCarry, oZero and oOverflow, output, 1 each, registered flags aligned with out.

Function
REQ-013 SHALL accept an operation when in_valid && in_ready at a rising edge.
REQ-014 SHALL decode ctrl as: 010 add, 110 sub, 000 and, 001 or, 111 xor, 100 shift-left logical, 101 shift-right logical, 011 multiply (see REQ-028); any other value passes data1 through.
REQ-015 SHALL compute add/sub at WIDTH+1 bits; oCarry = bit WIDTH (sub: 1 = borrow, i.e. data1 < data2 unsigned).
REQ-016 SHALL set oOverflow on add/sub signed overflow; oOverflow = 0 and oCarry = 0 for all other ops.
REQ-017 SHALL set oZero = 1 exactly when the registered out is all zeros, for every op.
REQ-018 SHALL shift by data2[SHW-1:0] only, zero-filling.
REQ-019 SHALL run FSM states IDLE, BUSY, HOLD: IDLE->HOLD on accepting a single-cycle op; IDLE->BUSY on accepting multiply; BUSY->HOLD when the iteration count reaches WIDTH; HOLD->IDLE on out_ready without a new accept; HOLD->HOLD on out_ready together with a new single-cycle accept; HOLD->BUSY on out_ready together with a new multiply accept.
REQ-020 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready); in_ready SHALL be 0 in BUSY.
REQ-021 SHALL give single-cycle ops a latency of 1: out_valid rises on the edge that accepts.
REQ-022 SHALL assert out_valid only in HOLD; out and all flags SHALL remain stable while out_valid && !out_ready.
REQ-023 SHALL sample operands at accept; operand changes afterwards SHALL NOT affect the result.
REQ-024 SHALL sustain one result per cycle for back-to-back single-cycle ops with out_ready held high.

Reset
REQ-025 SHALL, on reset low, immediately force state IDLE, out_valid 0, out 0, oCarry 0, oZero 0, oOverflow 0 and clear the multiply counter, independent of clk.
REQ-026 SHALL abandon any in-progress multiply on reset; no result of it SHALL appear after release.
REQ-027 SHALL present in_ready = 1 on the first edge after reset release.

Configuration
REQ-028 SHALL, with macro ALU_PIPE_MUL_EN defined, implement ctrl 011 as an unsigned iterative shift-add multiply, one partial product per cycle, WIDTH cycles in BUSY, out = low WIDTH bits of the product, oCarry = 1 when the upper WIDTH bits are nonzero; latency WIDTH+1 edges from accept to out_valid.
REQ-029 SHALL, without ALU_PIPE_MUL_EN, contain no BUSY state logic or counter, treat ctrl 011 as pass-through of data1 with latency 1, and keep in_ready = (state==IDLE) || out_ready.

Verification
REQ-030 SHALL cover: add 0xFFFFFFFF + 0x00000001 -> out 0x00000000, oCarry 1, oZero 1, oOverflow 0, out_valid one edge after accept.
REQ-031 SHALL cover: sub 0x00000005 - 0x00000007 -> out 0xFFFFFFFE, oCarry 1, oZero 0; add 0x7FFFFFFF + 1 -> out 0x80000000, oOverflow 1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles after an xor result -> in_ready 0, out and flags unchanged; out_ready 1 with new in_valid -> next result on the following edge.
REQ-033 SHALL cover: shift-left 0x00000001 by data2 0x00000024 -> out 0x00000010 (amount 4 with WIDTH=32).
REQ-034 SHALL cover with ALU_PIPE_MUL_EN: multiply 7 x 6 -> out 0x0000002A, oCarry 0 after 33 edges; 0x00010000 x 0x00010000 -> out 0, oCarry 1, oZero 1.
REQ-035 SHALL cover: reset low at cycle 10 of a multiply -> out_valid 0 immediately, no result after release, in_ready 1 on the first edge after release.
